uart_tx_buffer: RTL and testbench

- Transmit-side byte queue between the user logic and the transmit input of the UART core (tx_start / tx_data / tx_done).
- The user pushes bytes at any rate up to one per clock. The block stores them in a FIFO.
- It launches one transmission at a time: a single-cycle tx_start pulse, then it waits for tx_done before issuing the next byte.
- It removes the need for user logic to track transmitter busy state.

---
 rtl/uart_tx_buffer.sv | 129 ++++++++++++
 tb/tb_uart_tx_buffer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffer.sv
// Transmit byte queue in front of a UART transmitter: buffers user bytes in a FIFO
// and launches them one at a time with a tx_start pulse, waiting for tx_done.
module uart_tx_buffer #(
    parameter int unsigned DBIT_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DBIT_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  busy,
    output logic                  tx_start,
    output logic [DBIT_WIDTH-1:0] tx_data,
    input  logic                  tx_done
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT
    } state_e;

    state_e                state_q, state_d;
    logic [DBIT_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  overflow_q, overflow_d;
    logic                  busy_q, busy_d;
    logic                  tx_start_q, tx_start_d;
    logic [DBIT_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  push;
    logic                  pop;

    // Launch FSM: pops one byte in IDLE, pulses tx_start, then waits for completion.
    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        busy_d     = busy_q;
        tx_data_d  = tx_data_q;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_q) begin
                    pop        = 1'b1;
                    tx_data_d  = mem_q[rd_ptr_q];
                    tx_start_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (tx_done) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO bookkeeping; a push while full is dropped even if a pop frees a slot.
    always_comb begin
        push       = wr_en && !full_q;
        wr_ptr_d   = push ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
        full_d     = (count_d == CW'(DEPTH));
        empty_d    = (count_d == '0);
        overflow_d = wr_en && full_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign busy     = busy_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer: launch latency, ordering, fill/overflow,
// pointer wrap, simultaneous push/pop and mid-transmission reset.
module tb_uart_tx_buffer;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       tx_done_auto;
    logic       tx_done_man;

    int total = 0;
    int bad   = 0;

    logic       auto_en;
    int         done_dly;
    logic [7:0] sent_q[$];
    bit         ord_q[$];
    int         start_cnt = 0;
    int         done_cnt  = 0;

    assign tx_done = tx_done_auto | tx_done_man;

    uart_tx_buffer #(.DBIT_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .busy     (busy),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_done  (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record each launched byte and whether the previous launch had completed first.
    always @(negedge clk) begin
        if (!rst && tx_done) done_cnt <= done_cnt + 1;
        if (!rst && tx_start) begin
            sent_q.push_back(tx_data);
            ord_q.push_back(done_cnt == start_cnt);
            start_cnt <= start_cnt + 1;
        end
    end

    // Model of the UART transmitter: completes done_dly cycles after each launch.
    initial tx_done_auto = 1'b0;
    always begin
        @(negedge clk);
        if (auto_en && tx_start && !rst) begin
            repeat (done_dly) @(posedge clk);
            #1 tx_done_auto = 1'b1;
            @(posedge clk);
            #1 tx_done_auto = 1'b0;
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "simulation timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!(empty && !busy) && n < 3000) begin
            step();
            n++;
        end
        chk(tag, 32'(n < 3000), 32'd1);
    endtask

    initial begin
        int base;
        int peak;
        int hits;
        bit stall_to;

        rst         = 1'b1;
        wr_en       = 1'b0;
        wr_data     = 8'h00;
        tx_done_man = 1'b0;
        auto_en     = 1'b0;
        done_dly    = 2;
        repeat (3) step();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        step();

        // Single byte: launch two edges after the push.
        wr_en = 1'b1; wr_data = 8'hA5;
        step();
        wr_en = 1'b0;
        chk("t1_count1", 32'(count), 32'd1);
        chk("t1_empty0", 32'(empty), 32'd0);
        chk("t1_nostart", 32'(tx_start), 32'd0);
        step();
        chk("t1_start", 32'(tx_start), 32'd1);
        chk("t1_data", 32'(tx_data), 32'hA5);
        chk("t1_count0", 32'(count), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        step();
        chk("t1_start_1cyc", 32'(tx_start), 32'd0);
        chk("t1_busy_hold", 32'(busy), 32'd1);
        chk("t1_data_hold", 32'(tx_data), 32'hA5);
        tx_done_man = 1'b1;
        step();
        tx_done_man = 1'b0;
        chk("t1_busy_clr", 32'(busy), 32'd0);
        repeat (3) step();
        chk("t1_no_restart", 32'(start_cnt), 32'd1);

        // Five consecutive pushes.
        base = sent_q.size();
        auto_en = 1'b1; done_dly = 3; peak = 0;
        for (int i = 1; i <= 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            step();
            if (int'(count) > peak) peak = int'(count);
        end
        wr_en = 1'b0;
        chk("t2_peak", 32'(peak), 32'd4);
        wait_idle("t2_drain");
        chk("t2_nsent", 32'(sent_q.size() - base), 32'd5);
        for (int i = 0; i < 5; i++) chk("t2_byte", 32'(sent_q[base + i]), 32'(i + 1));
        chk("t2_empty", 32'(empty), 32'd1);

        // Fill with completion withheld, then overflow.
        auto_en = 1'b0;
        base = sent_q.size();
        wr_en = 1'b1; wr_data = 8'h10;
        step();
        wr_en = 1'b0;
        repeat (2) step();
        chk("t3_inflight", 32'(busy), 32'd1);
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h20 + i);
            step();
        end
        chk("t3_count16", 32'(count), 32'd16);
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_no_ovf", 32'(overflow), 32'd0);
        wr_data = 8'hEE;
        step();
        wr_en = 1'b0;
        chk("t3_ovf", 32'(overflow), 32'd1);
        chk("t3_ovf_count", 32'(count), 32'd16);
        step();
        chk("t3_ovf_pulse", 32'(overflow), 32'd0);
        chk("t3_count_kept", 32'(count), 32'd16);
        auto_en = 1'b1; done_dly = 2;
        tx_done_man = 1'b1;
        step();
        tx_done_man = 1'b0;
        wait_idle("t3_drain");
        chk("t3_nsent", 32'(sent_q.size() - base), 32'd17);
        chk("t3_first", 32'(sent_q[base]), 32'h10);
        for (int i = 0; i < 16; i++) chk("t3_byte", 32'(sent_q[base + 1 + i]), 32'(8'h20 + i));
        hits = 0;
        for (int i = base; i < sent_q.size(); i++) if (sent_q[i] == 8'hEE) hits++;
        chk("t3_no_ee", 32'(hits), 32'd0);

        // Stream 40 bytes across pointer wrap.
        base = sent_q.size();
        done_dly = 10; stall_to = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (full) begin
                int n;
                wr_en = 1'b0; n = 0;
                while (full && n < 200) begin step(); n++; end
                if (n >= 200) stall_to = 1'b1;
            end
            wr_en = 1'b1; wr_data = 8'(i);
            step();
        end
        wr_en = 1'b0;
        chk("t4_stall", 32'(stall_to), 32'd0);
        wait_idle("t4_drain");
        chk("t4_nsent", 32'(sent_q.size() - base), 32'd40);
        for (int i = 0; i < 40; i++) chk("t4_byte", 32'(sent_q[base + i]), 32'(i));

        // Push on the same edge as the internal pop.
        auto_en = 1'b0;
        base = sent_q.size();
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h50 + i);
            step();
        end
        wr_en = 1'b0;
        chk("t5_pre_count", 32'(count), 32'd3);
        chk("t5_pre_busy", 32'(busy), 32'd1);
        tx_done_man = 1'b1;
        step();
        tx_done_man = 1'b0;
        chk("t5_idle_count", 32'(count), 32'd3);
        wr_en = 1'b1; wr_data = 8'h54;
        step();
        wr_en = 1'b0;
        auto_en = 1'b1; done_dly = 2;
        chk("t5_start", 32'(tx_start), 32'd1);
        chk("t5_data", 32'(tx_data), 32'h51);
        chk("t5_count", 32'(count), 32'd3);
        wait_idle("t5_drain");
        chk("t5_nsent", 32'(sent_q.size() - base), 32'd5);
        for (int i = 0; i < 5; i++) chk("t5_byte", 32'(sent_q[base + i]), 32'(8'h50 + i));

        // Reset while waiting with five bytes queued.
        auto_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h60 + i);
            step();
        end
        wr_en = 1'b0;
        chk("t6_pre_count", 32'(count), 32'd5);
        chk("t6_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #2;
        chk("t6_rst_count", 32'(count), 32'd0);
        chk("t6_rst_empty", 32'(empty), 32'd1);
        chk("t6_rst_full", 32'(full), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_start", 32'(tx_start), 32'd0);
        chk("t6_rst_data", 32'(tx_data), 32'd0);
        chk("t6_rst_ovf", 32'(overflow), 32'd0);
        repeat (2) step();
        rst = 1'b0;
        base = start_cnt;
        tx_done_man = 1'b1;
        step();
        tx_done_man = 1'b0;
        repeat (10) step();
        chk("t6_no_start", 32'(start_cnt), 32'(base));
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_empty", 32'(empty), 32'd1);

        // Every launch must follow completion of the previous one.
        hits = 0;
        for (int i = 0; i < ord_q.size(); i++) if (!ord_q[i]) hits++;
        chk("launch_order", 32'(hits), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
